// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// Byte 0 of every 128-bit block sits in bits [127:120]; bytes fill the state column-major.
// Optional build macro AES_COMPLEMENTARY_OUT_EN adds a registered complement of the
// ciphertext plus its own valid strobe.
module aes_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
`ifdef AES_COMPLEMENTARY_OUT_EN
  output logic [127:0] AES_data_out_complementary,
  output logic         AES_data_out_complementary_valid,
`endif
  output logic         AES_data_out_valid
);

  typedef enum logic {StIdle, StRun} fsm_e;

  fsm_e         fsm_q;
  logic [3:0]   round_q;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [127:0] data_out_q;
  logic         valid_q;
`ifdef AES_COMPLEMENTARY_OUT_EN
  logic [127:0] comp_out_q;
  logic         comp_valid_q;
`endif

  logic [127:0] next_key;
  logic [127:0] round_out;
  logic [7:0]   rcon;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, x);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, x);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, x);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, x);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, x);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for the round key being derived.
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Key schedule step: round key r from round key r-1.
  always_comb begin
    logic [31:0] w3;
    logic [31:0] rot;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;
    w3   = key_q[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0   = key_q[127:96] ^ temp;
    n1   = key_q[95:64] ^ n0;
    n2   = key_q[63:32] ^ n1;
    n3   = key_q[31:0] ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // One cipher round: SubBytes, ShiftRows, MixColumns (skipped in round 10), AddRoundKey.
  always_comb begin
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] sr_flat;
    logic [127:0] mc_flat;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_q[127 - 8*i -: 8]);
    end
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
      end
    end
    sr_flat = '0;
    mc_flat = '0;
    for (int i = 0; i < 16; i++) begin
      sr_flat[127 - 8*i -: 8] = sr[i];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      mc_flat[127 - 32*c -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc_flat[119 - 32*c -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc_flat[111 - 32*c -: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc_flat[103 - 32*c -: 8]  = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    round_out = ((round_q == 4'd10) ? sr_flat : mc_flat) ^ next_key;
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm_q        <= StIdle;
      round_q      <= 4'd0;
      state_q      <= '0;
      key_q        <= '0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
`ifdef AES_COMPLEMENTARY_OUT_EN
      comp_out_q   <= '0;
      comp_valid_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef AES_COMPLEMENTARY_OUT_EN
      comp_valid_q <= 1'b0;
`endif
      case (fsm_q)
        StIdle: begin
          if (AES_en) begin
            state_q <= AES_data_in ^ AES_key_in;
            key_q   <= AES_key_in;
            round_q <= 4'd1;
            fsm_q   <= StRun;
          end
        end
        StRun: begin
          state_q <= round_out;
          key_q   <= next_key;
          if (round_q == 4'd10) begin
            data_out_q   <= round_out;
            valid_q      <= 1'b1;
`ifdef AES_COMPLEMENTARY_OUT_EN
            comp_out_q   <= ~round_out;
            comp_valid_q <= 1'b1;
`endif
            round_q      <= 4'd0;
            fsm_q        <= StIdle;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign AES_data_out       = data_out_q;
  assign AES_data_out_valid = valid_q;
`ifdef AES_COMPLEMENTARY_OUT_EN
  assign AES_data_out_complementary       = comp_out_q;
  assign AES_data_out_complementary_valid = comp_valid_q;
`endif

endmodule

// File: tb/tb_aes_top.sv
// Scoreboard bench for aes_top: expected ciphertext and capture cycle are queued when a
// block is started and checked by a monitor whenever the valid strobe appears.
module tb_aes_top;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  logic         data_out_valid;
`ifdef AES_COMPLEMENTARY_OUT_EN
  logic [127:0] data_out_comp;
  logic         data_out_comp_valid;
`endif

  aes_top u_dut (
    .AES_clk                          (clk),
    .AES_rst_n                        (rst_n),
    .AES_en                           (en),
    .AES_data_in                      (data_in),
    .AES_key_in                       (key_in),
    .AES_data_out                     (data_out),
`ifdef AES_COMPLEMENTARY_OUT_EN
    .AES_data_out_complementary       (data_out_comp),
    .AES_data_out_complementary_valid (data_out_comp_valid),
`endif
    .AES_data_out_valid               (data_out_valid)
  );

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CtZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] ct;
    int           cap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   pulses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued block and its latency.
  always @(negedge clk) begin
    if (rst_n && data_out_valid === 1'b1) begin
      exp_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ciphertext", data_out, e.ct);
        check_eq("latency", 128'(cyc - e.cap), 128'd10);
`ifdef AES_COMPLEMENTARY_OUT_EN
        check_eq("comp_data", data_out_comp, ~e.ct);
        check_eq("comp_valid", {127'd0, data_out_comp_valid}, 128'd1);
`endif
      end
    end
  end

  // Starts one block from a negedge; capture happens at the next posedge.
  task automatic start_block(input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] ct, input bit track);
    exp_t e;
    en      = 1'b1;
    data_in = pt;
    key_in  = k;
    if (track) begin
      e.ct  = ct;
      e.cap = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, data_out, 128'd0);
    check_eq({tag, "_valid"}, {127'd0, data_out_valid}, 128'd0);
`ifdef AES_COMPLEMENTARY_OUT_EN
    check_eq({tag, "_comp"}, data_out_comp, 128'd0);
    check_eq({tag, "_comp_valid"}, {127'd0, data_out_comp_valid}, 128'd0);
`endif
  endtask

  initial begin
    int base;
    exp_t e;
    rst_n   = 1'b0;
    en      = 1'b0;
    data_in = '0;
    key_in  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 App B, then output must hold while idle.
    start_block(PtB, KeyB, CtB, 1'b1);
    wait_drain(20);
    repeat (5) @(negedge clk);
    check_eq("hold_after_b", data_out, CtB);

    // App C with inputs scrambled mid-run.
    start_block(PtC, KeyC, CtC, 1'b1);
    repeat (4) @(negedge clk);
    data_in = {$urandom, $urandom, $urandom, $urandom};
    key_in  = {$urandom, $urandom, $urandom, $urandom};
    en      = 1'b0;
    wait_drain(20);

    // All-zero key and plaintext.
    start_block(128'd0, 128'd0, CtZ, 1'b1);
    wait_drain(20);

    // Reset in the middle of a run: outputs clear, no valid follows.
    start_block(PtB, KeyB, CtB, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("no_valid_after_abort", data_out, 128'd0);
    start_block(PtB, KeyB, CtB, 1'b1);
    wait_drain(20);

    // Back-to-back: en high for 51 edges gives captures every 11 cycles.
    en      = 1'b1;
    data_in = PtC;
    key_in  = KeyC;
    base    = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      e.ct  = CtC;
      e.cap = base + 11 * k;
      exp_q.push_back(e);
    end
    repeat (51) @(negedge clk);
    en      = 1'b0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    wait_drain(30);
    repeat (25) @(negedge clk);
    check_eq("hold_after_b2b", data_out, CtC);
    check_eq("pulse_count", 128'(pulses), 128'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
